// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch controller: owns the PC, drives the
// imem req/gnt/rvalid port and holds each fetched word for decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  output logic [31:0]      instr_o,
  output logic             instr_valid_o,
  output logic [31:0]      pc_o,
  input  logic             instr_ack_i,
  input  logic [31:0]      next_pc_i,
  output logic             illegal_instr_o,
  output logic             misaligned_pc_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    HALT
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               ill_q, ill_d;
  logic               mis_q, mis_d;
  logic               op_ok;
  logic [6:0]         op;

  assign op = imem_rdata_i[6:0];

  always_comb begin
    op_ok = 1'b0;
    unique case (1'b1)
      op == 7'b0110011,
      op == 7'b0000011,
      op == 7'b0010011,
      op == 7'b1100111,
      op == 7'b0100011,
      op == 7'b1100011,
      op == 7'b0010111,
      op == 7'b0110111,
      op == 7'b1101111: op_ok = 1'b1;
      default:          op_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    ill_d     = ill_q;
    mis_d     = mis_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          if (op_ok) begin
            state_d = VALID;
          end else begin
            state_d = HALT;
            ill_d   = 1'b1;
          end
        end
      end
      VALID: begin
        if (instr_ack_i) begin
          // retires even when the redirect target faults
          instret_d = instret_q + CNT_W'(1);
          if (next_pc_i[1:0] == 2'b00) begin
            pc_d    = next_pc_i;
            state_d = REQ;
          end else begin
            mis_d   = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
      ill_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      ill_q     <= ill_d;
      mis_q     <= mis_d;
    end
  end

  assign imem_req_o      = (state_q == REQ);
  assign imem_addr_o     = pc_q;
  assign instr_o         = instr_q;
  assign instr_valid_o   = (state_q == VALID);
  assign pc_o            = pc_q;
  assign illegal_instr_o = ill_q;
  assign misaligned_pc_o = mis_q;
  assign halted_o        = (state_q == HALT);
  assign instret_o       = instret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetch, backpressure, redirect,
// illegal opcode, misaligned PC, stray inputs and reset mid-fetch.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic        instr_ack_i;
  logic [31:0] next_pc_i;
  logic        illegal_instr_o;
  logic        misaligned_pc_o;
  logic        halted_o;
  logic [31:0] instret_o;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .RESET_PC(32'h0000_0000),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o),
    .instr_valid_o(instr_valid_o),
    .pc_o(pc_o),
    .instr_ack_i(instr_ack_i),
    .next_pc_i(next_pc_i),
    .illegal_instr_o(illegal_instr_o),
    .misaligned_pc_o(misaligned_pc_o),
    .halted_o(halted_o),
    .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    instr_ack_i   = 1'b0;
    next_pc_i     = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle_in();
    do_reset();
    // cycle 0: IDLE, reset values
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_instret", instret_o, 32'h0);
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_flags", {29'h0, illegal_instr_o, misaligned_pc_o,
                      halted_o}, 32'h0);
    tick();
    chk("c1_req", 32'(imem_req_o), 32'h1);
    chk("c1_addr", imem_addr_o, 32'h0);
    imem_gnt_i = 1'b1;
    tick();
    chk("c2_req", 32'(imem_req_o), 32'h0);
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0020_8133;
    tick();
    idle_in();
    chk("c3_valid", 32'(instr_valid_o), 32'h1);
    chk("c3_instr", instr_o, 32'h0020_8133);
    chk("c3_pc", pc_o, 32'h0);
    tick();
    chk("hold_valid", 32'(instr_valid_o), 32'h1);
    chk("hold_instr", instr_o, 32'h0020_8133);

    // ack with redirect
    instr_ack_i = 1'b1;
    next_pc_i   = 32'h0000_0100;
    tick();
    idle_in();
    chk("ack_valid", 32'(instr_valid_o), 32'h0);
    chk("ack_instret", instret_o, 32'h1);
    chk("ack_req", 32'(imem_req_o), 32'h1);
    chk("ack_addr", imem_addr_o, 32'h100);

    // grant withheld 3 cycles, stray rvalid during REQ
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0000_007F;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_req", 32'(imem_req_o), 32'h1);
      chk("bp_addr", imem_addr_o, 32'h100);
    end
    chk("stray_rv_flag", 32'(illegal_instr_o), 32'h0);
    idle_in();
    imem_gnt_i = 1'b1;
    tick();
    chk("bp_wait", 32'(imem_req_o), 32'h0);
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0000_0013;
    tick();
    idle_in();
    chk("bp_valid", 32'(instr_valid_o), 32'h1);
    chk("bp_instr", instr_o, 32'h0000_0013);
    chk("bp_pc", pc_o, 32'h100);
    chk("bp_instret", instret_o, 32'h1);

    // stray ack in WAIT, then reset mid-fetch
    instr_ack_i = 1'b1;
    next_pc_i   = 32'h0000_0104;
    tick();
    idle_in();
    chk("a2_instret", instret_o, 32'h2);
    chk("a2_addr", imem_addr_o, 32'h104);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i  = 1'b0;
    instr_ack_i = 1'b1;
    next_pc_i   = 32'h0000_0200;
    tick();
    chk("sack_req", 32'(imem_req_o), 32'h0);
    chk("sack_valid", 32'(instr_valid_o), 32'h0);
    chk("sack_instret", instret_o, 32'h2);
    chk("sack_pc", pc_o, 32'h104);
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_req", 32'(imem_req_o), 32'h0);
    chk("mid_rst_pc", pc_o, 32'h0);
    chk("mid_rst_instret", instret_o, 32'h0);

    // illegal opcode
    tick();
    chk("il_req", 32'(imem_req_o), 32'h1);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0000_007F;
    tick();
    idle_in();
    chk("il_flag", 32'(illegal_instr_o), 32'h1);
    chk("il_halt", 32'(halted_o), 32'h1);
    chk("il_valid", 32'(instr_valid_o), 32'h0);
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b1;
    instr_ack_i   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("il_noreq", {30'h0, imem_req_o, instr_valid_o}, 32'h0);
    end
    chk("il_stay", {30'h0, illegal_instr_o, halted_o}, 32'h3);

    // misaligned redirect and recovery
    do_reset();
    tick();
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0020_8133;
    tick();
    idle_in();
    chk("mis_pre_valid", 32'(instr_valid_o), 32'h1);
    chk("mis_pre_ill", 32'(illegal_instr_o), 32'h0);
    instr_ack_i = 1'b1;
    next_pc_i   = 32'h0000_0102;
    tick();
    idle_in();
    chk("mis_flag", 32'(misaligned_pc_o), 32'h1);
    chk("mis_halt", 32'(halted_o), 32'h1);
    chk("mis_instret", instret_o, 32'h1);
    chk("mis_pc", pc_o, 32'h0);
    chk("mis_valid", 32'(instr_valid_o), 32'h0);
    tick();
    chk("mis_noreq", 32'(imem_req_o), 32'h0);
    do_reset();
    chk("rec_pc", pc_o, 32'h0);
    chk("rec_flags", {29'h0, illegal_instr_o, misaligned_pc_o,
                      halted_o}, 32'h0);
    chk("rec_instret", instret_o, 32'h0);
    tick();
    chk("rec_req", 32'(imem_req_o), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
